// File: rtl/pcs_tx_pkg.sv
// ---------------------------------------------------------------------------
// pcs_tx_pkg
// Shared definitions for the PCS transmit path: default word width and stage
// depth, the default word type, and a constant-evaluable ceil(log2) helper
// used to size pointers and the occupancy counter.
// No ports (package).
// ---------------------------------------------------------------------------
package pcs_tx_pkg;

    localparam int TX_WR_WIDTH_DEF    = 12;
    localparam int TX_STAGE_DEPTH_DEF = 4;

    typedef logic [TX_WR_WIDTH_DEF-1:0] tx_word_t;

    // ceil(log2(value)), minimum 1 so a 1-bit field is never sized to zero.
    function automatic int clog2_f(input int value);
        int result;
        result = 1;
        for (int i = 1; i < 31; i++) begin
            result = (int'(32'd1 << i) < value) ? (i + 1) : result;
        end
        return result;
    endfunction

endpackage

// File: rtl/tx_stage_regfile.sv
// ---------------------------------------------------------------------------
// tx_stage_regfile
// DEPTH x WR_WIDTH flop array backing the TX stage buffer.
// Ports:
//   clock  in   rising-edge clock
//   we     in   write enable
//   waddr  in   write address (AW bits)
//   wdata  in   write data (WR_WIDTH bits)
//   raddr  in   read address (AW bits)
//   rdata  out  asynchronous read data (WR_WIDTH bits)
// Contents are deliberately not reset; validity is tracked by the parent.
// ---------------------------------------------------------------------------
module tx_stage_regfile
    import pcs_tx_pkg::*;
#(
    parameter int WR_WIDTH = TX_WR_WIDTH_DEF,
    parameter int DEPTH    = TX_STAGE_DEPTH_DEF,
    parameter int AW       = clog2_f(DEPTH)
) (
    input  logic                clock,
    input  logic                we,
    input  logic [AW-1:0]       waddr,
    input  logic [WR_WIDTH-1:0] wdata,
    input  logic [AW-1:0]       raddr,
    output logic [WR_WIDTH-1:0] rdata
);

    logic [WR_WIDTH-1:0] mem_r [DEPTH];

    // Single write port into the storage array.
    always_ff @(posedge clock) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    // Asynchronous read of the addressed entry.
    always_comb begin
        rdata = mem_r[raddr];
    end

endmodule

// File: rtl/tx_stage_buffer.sv
// ---------------------------------------------------------------------------
// tx_stage_buffer
// Elastic DEPTH-entry stage between the TX FIFO and the escaper.
// Ports:
//   clock         in   rising-edge clock
//   reset         in   synchronous, active-high
//   in_enable     in   global enable; low freezes all transfers and state
//   en_fifo       in   upstream word valid
//   data_fifo     in   upstream word (WR_WIDTH)
//   idle_fifo     out  stage can take a word this cycle
//   en_escaper    out  word handed to the escaper this cycle
//   data_escaper  out  head word (zero when nothing to present)
//   idle_escaper  in   escaper can accept this cycle
//   level         out  stored-entry count (CW bits)
//   almost_full   out  registered level >= AF_LEVEL
//   proto_err     out  sticky: word offered while the stage refused it
// Build option: define TX_STAGE_BYPASS_EN to let a word offered to an empty
// stage with a ready escaper pass straight through in the same cycle.
// ---------------------------------------------------------------------------
module tx_stage_buffer
    import pcs_tx_pkg::*;
#(
    parameter int WR_WIDTH = TX_WR_WIDTH_DEF,
    parameter int DEPTH    = TX_STAGE_DEPTH_DEF,
    parameter int AF_LEVEL = 3,
    localparam int CW      = clog2_f(DEPTH + 1)
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                in_enable,
    input  logic                en_fifo,
    input  logic [WR_WIDTH-1:0] data_fifo,
    output logic                idle_fifo,
    output logic                en_escaper,
    output logic [WR_WIDTH-1:0] data_escaper,
    input  logic                idle_escaper,
    output logic [CW-1:0]       level,
    output logic                almost_full,
    output logic                proto_err
);

    localparam int            PW       = clog2_f(DEPTH);
    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C     = CW'(AF_LEVEL);
    localparam logic [CW-1:0] ONE_C    = CW'(1);
    localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

    logic [PW-1:0]       rd_ptr_r;
    logic [PW-1:0]       wr_ptr_r;
    logic [CW-1:0]       count_r;
    logic                almost_full_r;
    logic                proto_err_r;

    logic                active_s;
    logic                has_data_s;
    logic                pop_s;
    logic                idle_s;
    logic                push_s;
    logic                bypass_s;
    logic                write_s;
    logic [WR_WIDTH-1:0] rdata_s;

    // Pointers wrap explicitly so DEPTH need not be a power of two.
    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] ptr);
        return (ptr == LAST_PTR) ? {PW{1'b0}} : (ptr + PW'(1));
    endfunction

    tx_stage_regfile #(
        .WR_WIDTH (WR_WIDTH),
        .DEPTH    (DEPTH),
        .AW       (PW)
    ) u_regfile (
        .clock (clock),
        .we    (write_s),
        .waddr (wr_ptr_r),
        .wdata (data_fifo),
        .raddr (rd_ptr_r),
        .rdata (rdata_s)
    );

    // Handshake decode: pop, acceptance, push and bypass qualification.
    always_comb begin
        active_s   = in_enable & ~reset;
        has_data_s = (count_r != {CW{1'b0}});
        pop_s      = active_s & idle_escaper & has_data_s;
        // A full stage still accepts when it is popping in the same cycle.
        idle_s     = active_s & ((count_r < DEPTH_C) | pop_s);
        push_s     = en_fifo & idle_s;
`ifdef TX_STAGE_BYPASS_EN
        bypass_s   = active_s & en_fifo & idle_escaper & ~has_data_s;
`else
        bypass_s   = 1'b0;
`endif
        // A bypassed word goes straight out and is never stored.
        write_s    = push_s & ~bypass_s;
    end

    // Pointer, occupancy, almost-full and protocol-error state.
    always_ff @(posedge clock) begin
        if (reset) begin
            rd_ptr_r      <= {PW{1'b0}};
            wr_ptr_r      <= {PW{1'b0}};
            count_r       <= {CW{1'b0}};
            almost_full_r <= 1'b0;
            proto_err_r   <= 1'b0;
        end else if (in_enable) begin
            if (write_s) begin
                wr_ptr_r <= next_ptr(wr_ptr_r);
            end
            if (pop_s) begin
                rd_ptr_r <= next_ptr(rd_ptr_r);
            end
            case ({write_s, pop_s})
                2'b10:   count_r <= count_r + ONE_C;
                2'b01:   count_r <= count_r - ONE_C;
                default: count_r <= count_r;
            endcase
            // Registered from the current count, so it trails level by one edge.
            almost_full_r <= (count_r >= AF_C);
            if (en_fifo & ~idle_s) begin
                proto_err_r <= 1'b1;
            end
        end
    end

    // Output drive; reset forces the combinational outputs to their idle values.
    always_comb begin
        en_escaper  = pop_s | bypass_s;
        idle_fifo   = idle_s;
        almost_full = almost_full_r;
        proto_err   = proto_err_r;
        if (reset) begin
            level        = {CW{1'b0}};
            data_escaper = {WR_WIDTH{1'b0}};
        end else begin
            level = count_r;
`ifdef TX_STAGE_BYPASS_EN
            if (bypass_s) begin
                data_escaper = data_fifo;
            end else if (has_data_s) begin
                data_escaper = rdata_s;
            end else begin
                data_escaper = {WR_WIDTH{1'b0}};
            end
`else
            if (has_data_s) begin
                data_escaper = rdata_s;
            end else begin
                data_escaper = {WR_WIDTH{1'b0}};
            end
`endif
        end
    end

endmodule

// File: tb/tb_tx_stage_buffer.sv
// ---------------------------------------------------------------------------
// tb_tx_stage_buffer
// Self-checking bench for tx_stage_buffer (WR_WIDTH=12, DEPTH=4, AF_LEVEL=3).
// A queue-based reference model predicts every observable output each cycle.
// Honours TX_STAGE_BYPASS_EN the same way the design does.
// ---------------------------------------------------------------------------
module tb_tx_stage_buffer;

    localparam int W  = 12;
    localparam int D  = 4;
    localparam int AF = 3;
    localparam int CW = 3;
`ifdef TX_STAGE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic          clock = 1'b0;
    logic          reset;
    logic          in_enable;
    logic          en_fifo;
    logic [W-1:0]  data_fifo;
    logic          idle_fifo;
    logic          en_escaper;
    logic [W-1:0]  data_escaper;
    logic          idle_escaper;
    logic [CW-1:0] level;
    logic          almost_full;
    logic          proto_err;

    tx_stage_buffer #(
        .WR_WIDTH (W),
        .DEPTH    (D),
        .AF_LEVEL (AF)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .in_enable    (in_enable),
        .en_fifo      (en_fifo),
        .data_fifo    (data_fifo),
        .idle_fifo    (idle_fifo),
        .en_escaper   (en_escaper),
        .data_escaper (data_escaper),
        .idle_escaper (idle_escaper),
        .level        (level),
        .almost_full  (almost_full),
        .proto_err    (proto_err)
    );

    always #5 clock = ~clock;

    // Reference model state
    logic [W-1:0]     q[$];
    bit               m_af;
    bit               m_perr;
    bit               c_rst, c_en, c_pop, c_push, c_byp, c_perr_hit;
    logic [W-1:0]     c_data;
    logic [W+CW+3:0]  exp_vec;

    int vectors     = 0;
    int miscompares = 0;

    function automatic logic [W+CW+3:0] obs();
        return {en_escaper, idle_fifo, data_escaper, level, almost_full, proto_err};
    endfunction

    // Apply one cycle of stimulus and predict this cycle's outputs.
    task automatic drive(input bit r, input bit en, input bit ie, input bit want,
                         input bit viol, input logic [W-1:0] d);
        int           sz;
        bit           pop, idle, ef, byp, e_en;
        logic [W-1:0] e_data;
        sz   = q.size();
        pop  = !r && en && ie && (sz > 0);
        idle = !r && en && ((sz < D) || pop);
        ef   = want && (idle || viol);
        byp  = BYP && !r && en && ef && ie && (sz == 0);
        reset        = r;
        in_enable    = en;
        idle_escaper = ie;
        en_fifo      = ef;
        data_fifo    = d;
        e_en   = pop || byp;
        e_data = r ? '0 : (byp ? d : ((sz > 0) ? q[0] : '0));
        exp_vec = {e_en, idle, e_data, (r ? 3'd0 : CW'(sz)), m_af, m_perr};
        c_rst = r; c_en = en; c_pop = pop; c_push = ef && idle; c_byp = byp;
        c_perr_hit = ef && !idle && en && !r;
        c_data = d;
    endtask

    // Clock edge: update the model with the decisions of the ending cycle.
    task automatic advance();
        @(posedge clock);
        if (c_rst) begin
            q.delete();
            m_af   = 1'b0;
            m_perr = 1'b0;
        end else if (c_en) begin
            m_af = (q.size() >= AF);
            if (c_pop) void'(q.pop_front());
            if (c_push && !c_byp) q.push_back(c_data);
            if (c_perr_hit) m_perr = 1'b1;
        end
        #1;
    endtask

    task automatic test_reset();
        drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 12'h123);
        advance();
        for (int i = 0; i < 3; i++) begin
            drive(i < 1, 1'b1, 1'b1, 1'b0, 1'b0, 12'h000);
            @(negedge clock);
            if (obs() !== exp_vec) begin
                miscompares++;
                $display("FAIL reset c%0d: got %h expected %h", i, obs(), exp_vec);
            end
            vectors++;
            advance();
        end
    endtask

    task automatic test_stream();
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 1'b1, 1'b1, i < 6, 1'b0, 12'(i + 1));
            @(negedge clock);
            if (obs() !== exp_vec || level > 3'd1) begin
                miscompares++;
                $display("FAIL stream c%0d: got %h expected %h", i, obs(), exp_vec);
            end
            vectors++;
            advance();
        end
    endtask

    task automatic test_fill();
        logic [W-1:0] src[$];
        logic [W-1:0] got[$];
        src = {12'h001, 12'h002, 12'h003, 12'h004, 12'h005};
        for (int i = 0; i < 14; i++) begin
            drive(1'b0, 1'b1, i >= 6, src.size() > 0, 1'b0,
                  (src.size() > 0) ? src[0] : 12'h000);
            @(negedge clock);
            if (obs() !== exp_vec) begin
                miscompares++;
                $display("FAIL fill c%0d: got %h expected %h", i, obs(), exp_vec);
            end
            vectors++;
            if (en_escaper) got.push_back(data_escaper);
            if (c_push) void'(src.pop_front());
            advance();
        end
        if (got.size() != 5) begin
            miscompares++;
            $display("FAIL fill_count: got %0d words expected 5", got.size());
        end else begin
            for (int k = 0; k < 5; k++) begin
                if (got[k] !== 12'(k + 1)) begin
                    miscompares++;
                    $display("FAIL fill_order w%0d: got %h expected %h", k, got[k], 12'(k + 1));
                end
            end
        end
        vectors++;
    endtask

    task automatic test_full_swap();
        for (int i = 0; i < 10; i++) begin
            drive(1'b0, 1'b1, i >= 4, i < 5, 1'b0, 12'h0A0 + 12'(i));
            @(negedge clock);
            if (obs() !== exp_vec) begin
                miscompares++;
                $display("FAIL full_swap c%0d: got %h expected %h", i, obs(), exp_vec);
            end
            vectors++;
            advance();
        end
    endtask

    task automatic test_freeze();
        for (int i = 0; i < 10; i++) begin
            drive(1'b0, !(i >= 3 && i < 6), 1'b1, 1'b1, 1'b1, 12'h300 + 12'(i));
            @(negedge clock);
            if (obs() !== exp_vec) begin
                miscompares++;
                $display("FAIL freeze c%0d: got %h expected %h", i, obs(), exp_vec);
            end
            vectors++;
            advance();
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 8; i++) begin
            drive(i == 3, 1'b1, i >= 3, i < 3, 1'b0, 12'h500 + 12'(i));
            @(negedge clock);
            if (obs() !== exp_vec) begin
                miscompares++;
                $display("FAIL reset_mid c%0d: got %h expected %h", i, obs(), exp_vec);
            end
            vectors++;
            advance();
        end
    endtask

    task automatic test_proto();
        for (int i = 0; i < 9; i++) begin
            drive(i == 7, 1'b1, 1'b0, 1'b1, i == 5, 12'h600 + 12'(i));
            @(negedge clock);
            if (obs() !== exp_vec) begin
                miscompares++;
                $display("FAIL proto c%0d: got %h expected %h", i, obs(), exp_vec);
            end
            vectors++;
            advance();
        end
    endtask

    task automatic test_bypass();
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b1, 1'b1, i == 0, 1'b0, 12'hABC);
            @(negedge clock);
            if (obs() !== exp_vec) begin
                miscompares++;
                $display("FAIL bypass c%0d: got %h expected %h", i, obs(), exp_vec);
            end
            vectors++;
            advance();
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            drive(($urandom % 40) == 0, ($urandom % 8) != 0, ($urandom % 3) != 0,
                  ($urandom % 4) != 0, ($urandom % 10) == 0, W'($urandom));
            @(negedge clock);
            if (obs() !== exp_vec) begin
                miscompares++;
                $display("FAIL random c%0d: got %h expected %h", i, obs(), exp_vec);
            end
            vectors++;
            advance();
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_fill();
        test_full_swap();
        test_freeze();
        test_reset_mid();
        test_proto();
        test_bypass();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
